wb_writeback: RTL and testbench
===============================

WB_WRITEBACK -- requirements
Module: wb_writeback

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles spent in REQ+WAIT before abort (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  write-back request valid.
REQ-005 in_ready  output  1  block can accept a request (high only in IDLE).
REQ-006 in_sel  input  2  source select: 00 memory load, 01 pc+4, 10 ALU result, 11 immediate.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_pc  input  32  instruction PC.
REQ-009 in_alu  input  32  ALU result; also the load address when in_sel=00.
REQ-010 in_imm  input  32  sign-extended immediate (lui value).
REQ-011 in_funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-012 mem_req  output  1  load read request.
REQ-013 mem_addr  output  32  word-aligned address {alu[31:2],2'b00}.
REQ-014 mem_gnt  input  1  request accepted by memory.
REQ-015 mem_rvalid  input  1  read data valid.
REQ-016 mem_rdata  input  32  read data word.
REQ-017 rf_we  output  1  register-file write enable.
REQ-018 rf_waddr  output  5  register-file write index.
REQ-019 rf_wdata  output  32  register-file write data.
REQ-020 done  output  1  one-cycle pulse on successful completion.
REQ-021 err  output  1  one-cycle pulse on misalign, illegal funct3 or timeout.

Function
REQ-022 FSM states IDLE, REQ, WAIT, WB; accept = in_valid & in_ready; all request fields latched on accept.
REQ-023 IDLE, accept, in_sel!=00 -> WB; wdata latched as in_pc+4 (01, mod 2^32), in_alu (10), in_imm (11).
REQ-024 IDLE, accept, in_sel=00, legal and aligned -> REQ.
REQ-025 Misaligned load (lh/lhu with alu[0]=1; lw with alu[1:0]!=0) or funct3 in {011,110,111}: stay IDLE, err=1 next cycle, no mem_req, no rf_we.
REQ-026 REQ: mem_req=1, mem_addr held stable until mem_gnt=1; on gnt -> WAIT.
REQ-027 WAIT: mem_req=0; on mem_rvalid=1 latch extracted data -> WB; mem_rvalid outside WAIT ignored.
REQ-028 Extraction: byte lane alu[1:0] (lb/lbu), halfword lane alu[1] (lh/lhu); lb/lh sign-extend, lbu/lhu zero-extend, lw full word.
REQ-029 WB: rf_we=1, rf_waddr=latched rd, rf_wdata=latched data, done=1 for exactly one cycle -> IDLE.
REQ-030 rd=0: WB still taken and done pulses, but rf_we=0.
REQ-031 Latency: non-load accept at cycle N -> rf_we at N+1; load rvalid at cycle R -> rf_we at R+1.
REQ-032 Timeout counter clears on accept, increments each cycle in REQ/WAIT; at TIMEOUT -> IDLE, err pulse, mem_req=0, no write.
REQ-033 mem_gnt and mem_rvalid in the same REQ cycle: treat as gnt only; rvalid must arrive in a later cycle.
REQ-034 in_ready=0 in REQ, WAIT and WB; in_valid there has no effect.

Reset
REQ-035 rst=1 forces IDLE immediately regardless of clk; in_ready=1; mem_req, rf_we, done, err=0; mem_addr, rf_waddr, rf_wdata, counter=0.
REQ-036 Reset mid-operation aborts the transaction with no register write and no done/err pulse.

Verification
REQ-037 sel=01, pc=0x80000000, rd=5 -> next cycle rf_we=1, waddr=5, wdata=0x80000004, done=1.
REQ-038 sel=00, funct3=000, alu=0x80000003, gnt 2 cycles later, rdata=0x80FF1234 -> mem_addr=0x80000000, wdata=0xFFFFFF80.
REQ-039 sel=00, funct3=101, alu=0x80000002, rdata=0x80FF1234 -> wdata=0x000080FF; funct3=010, alu=0x80000001 -> err pulse, no mem_req.
REQ-040 sel=10, rd=0, alu=0x1234 -> done=1, rf_we=0.
REQ-041 TIMEOUT=4, load accepted, gnt never asserted -> err pulse after 4 cycles in REQ, back to IDLE, in_ready=1.
REQ-042 rst asserted while in WAIT, then rvalid -> no rf_we, no done; block in IDLE with reset outputs.

Source files
------------

// File: rtl/wb_writeback.sv
// Write-back stage: selects the register-file write value, and for loads
// issues one memory read, extracts the addressed byte/halfword/word and writes it back.
module wb_writeback #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_sel,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_imm,
    input  logic [2:0]  in_funct3,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        load_bad;
    logic [31:0] lane_shifted;
    logic [15:0] half_word;
    logic [31:0] load_data;

    // Illegal funct3 or an access that crosses its natural alignment.
    always_comb begin
        load_bad = 1'b0;
        unique case (in_funct3)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = in_alu[0];
            3'b010:         load_bad = (in_alu[1:0] != 2'b00);
            default:        load_bad = 1'b1;
        endcase
    end

    always_comb begin
        lane_shifted = mem_rdata >> {lane_q, 3'b000};
        half_word    = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data    = mem_rdata;
        unique case (funct3_q)
            3'b000:  load_data = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
            3'b100:  load_data = {24'h000000, lane_shifted[7:0]};
            3'b001:  load_data = {{16{half_word[15]}}, half_word};
            3'b101:  load_data = {16'h0000, half_word};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        data_d   = data_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rd_d     = in_rd;
                    funct3_d = in_funct3;
                    lane_d   = in_alu[1:0];
                    addr_d   = {in_alu[31:2], 2'b00};
                    cnt_d    = 8'd0;
                    unique case (in_sel)
                        2'b01: begin
                            data_d  = in_pc + 32'd4;
                            state_d = S_WB;
                        end
                        2'b10: begin
                            data_d  = in_alu;
                            state_d = S_WB;
                        end
                        2'b11: begin
                            data_d  = in_imm;
                            state_d = S_WB;
                        end
                        default: begin
                            if (load_bad) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = S_REQ;
                            end
                        end
                    endcase
                end
            end
            // A grant in the final allowed cycle still aborts: no cycle would remain for the data.
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    data_d  = load_data;
                    state_d = S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rd_q     <= 5'd0;
            data_q   <= 32'd0;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            lane_q   <= 2'd0;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign mem_req  = (state_q == S_REQ);
    assign mem_addr = addr_q;
    assign rf_we    = (state_q == S_WB) && (rd_q != 5'd0);
    assign rf_waddr = rd_q;
    assign rf_wdata = data_q;
    assign done     = (state_q == S_WB);
    assign err      = err_q;

endmodule

// File: tb/tb_wb_writeback.sv
// Randomized scoreboard bench for wb_writeback: the driver predicts each outcome
// from the load/select rules, and a negedge monitor pops and compares DUT results.
module tb_wb_writeback;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_sel = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_alu = '0;
    logic [31:0] in_imm = '0;
    logic [2:0]  in_funct3 = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done;
    logic        err;

    wb_writeback #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_rd(in_rd),
        .in_pc(in_pc), .in_alu(in_alu), .in_imm(in_imm), .in_funct3(in_funct3),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        bit          we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          exp_mem_ok = 1'b0;
    logic [31:0] exp_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " mem_req"},  32'(mem_req),  32'd0);
        checkOutput({tag, " rf_we"},    32'(rf_we),    32'd0);
        checkOutput({tag, " done"},     32'(done),     32'd0);
        checkOutput({tag, " err"},      32'(err),      32'd0);
        checkOutput({tag, " mem_addr"}, mem_addr,      32'd0);
        checkOutput({tag, " rf_waddr"}, 32'(rf_waddr), 32'd0);
        checkOutput({tag, " rf_wdata"}, rf_wdata,      32'd0);
    endtask

    // Reference rules for load legality and data extraction.
    function automatic bit load_legal(input logic [2:0] f3, input logic [31:0] alu);
        case (f3)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return (alu % 2) == 0;
            3'b010:         return (alu % 4) == 0;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata);
        int          byte_idx;
        int          half_idx;
        logic [7:0]  b;
        logic [15:0] h;
        byte_idx = int'(alu % 4);
        half_idx = int'((alu / 2) % 2);
        b = 8'((rdata / (32'd1 << (8 * byte_idx))) % 256);
        h = 16'((rdata / (32'd1 << (16 * half_idx))) % 65536);
        case (f3)
            3'b000:  return (b >= 8'h80)  ? 32'(b) - 32'd256   : 32'(b);
            3'b100:  return 32'(b);
            3'b001:  return (h >= 16'h8000) ? 32'(h) - 32'd65536 : 32'(h);
            3'b101:  return 32'(h);
            default: return rdata;
        endcase
    endfunction

    task automatic applyStimulus(input string tag, input logic [1:0] sel, input logic [4:0] rd,
                                 input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] imm,
                                 input logic [2:0] f3, input int gd, input int rdl, input logic [31:0] rdata);
        exp_t e;
        int   guard;
        int   a;
        bit   is_load;
        bit   legal;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s ready wait: got in_ready=%b, want 1 within 20 cycles", tag, in_ready);
        end
        is_load    = (sel == 2'b00);
        legal      = load_legal(f3, alu);
        exp_addr   = {alu[31:2], 2'b00};
        exp_mem_ok = is_load && legal;
        in_valid = 1'b1; in_sel = sel; in_rd = rd; in_pc = pc;
        in_alu = alu; in_imm = imm; in_funct3 = f3;
        tick();
        a = cyc;
        in_valid = 1'b0; in_sel = 2'($urandom); in_rd = 5'($urandom);
        in_pc = $urandom; in_alu = $urandom; in_imm = $urandom; in_funct3 = 3'($urandom);
        e.tag = tag; e.waddr = rd; e.we = (rd != 0); e.is_err = 1'b0; e.cyc = a; e.wdata = '0;
        if (sel == 2'b01)      e.wdata = pc + 32'd4;
        else if (sel == 2'b10) e.wdata = alu;
        else if (sel == 2'b11) e.wdata = imm;
        else if (!legal)       e.is_err = 1'b1;
        else if (gd + rdl + 2 <= TIMEOUT) begin
            e.wdata = load_value(f3, alu, rdata);
            e.cyc   = a + gd + 2 + rdl;
        end else begin
            e.is_err = 1'b1;
            e.cyc    = a + TIMEOUT;
        end
        exp_q.push_back(e);
        if (is_load && legal) begin
            for (int k = 0; k < gd; k++) begin
                mem_rvalid = 1'($urandom);
                mem_rdata  = $urandom;
                tick();
            end
            mem_gnt    = 1'b1;
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            tick();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            repeat (rdl) tick();
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        exp_mem_ok = 1'b0;
    endtask

    // Monitor: every completion or error is matched against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!rst) begin
            if (mem_req) begin
                n_vec++;
                if (!exp_mem_ok || mem_addr !== exp_addr) begin
                    n_fail++;
                    $display("[TB] FAIL mem_addr: got req=1 addr=%h, want allowed=%b addr=%h", mem_addr, exp_mem_ok, exp_addr);
                end
            end
            if (done || err || rf_we) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected: got done=%b err=%b we=%b at cycle %0d, want no event", done, err, rf_we, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err)
                        ok = (err === 1'b1) && (done === 1'b0) && (rf_we === 1'b0) &&
                             (in_ready === 1'b1) && (mem_req === 1'b0) && (cyc == e.cyc);
                    else
                        ok = (done === 1'b1) && (err === 1'b0) && (rf_we === e.we) &&
                             (rf_waddr === e.waddr) && (rf_wdata === e.wdata) && (cyc == e.cyc);
                    if (!ok) begin
                        n_fail++;
                        $display("[TB] FAIL %s: got done=%b err=%b we=%b waddr=%0d wdata=%h cyc=%0d, want err=%b we=%b waddr=%0d wdata=%h cyc=%0d",
                                 e.tag, done, err, rf_we, rf_waddr, rf_wdata, cyc, e.is_err, e.we, e.waddr, e.wdata, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #3;
        checkResetOutputs("reset");
        repeat (3) tick();
        rst = 1'b0;
        tick();

        applyStimulus("pc4",       2'b01, 5'd5,  32'h8000_0000, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
        applyStimulus("lb",        2'b00, 5'd7,  32'h0, 32'h8000_0003, 32'h0, 3'b000, 2, 0, 32'h80FF_1234);
        applyStimulus("lhu",       2'b00, 5'd9,  32'h0, 32'h8000_0002, 32'h0, 3'b101, 0, 1, 32'h80FF_1234);
        applyStimulus("lw_misal",  2'b00, 5'd3,  32'h0, 32'h8000_0001, 32'h0, 3'b010, 0, 0, 32'h0);
        applyStimulus("rd0",       2'b10, 5'd0,  32'h0, 32'h0000_1234, 32'h0, 3'b000, 0, 0, 32'h0);
        applyStimulus("imm",       2'b11, 5'd31, 32'h0, 32'h0, 32'hFFFF_F000, 3'b000, 0, 0, 32'h0);
        applyStimulus("pc_wrap",   2'b01, 5'd1,  32'hFFFF_FFFC, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
        applyStimulus("bad_f3",    2'b00, 5'd4,  32'h0, 32'h0000_0100, 32'h0, 3'b110, 0, 0, 32'h0);
        applyStimulus("timeout",   2'b00, 5'd6,  32'h0, 32'h0000_0040, 32'h0, 3'b010, 6, 0, 32'h1111_2222);
        applyStimulus("wait_to",   2'b00, 5'd6,  32'h0, 32'h0000_0040, 32'h0, 3'b010, 1, 1, 32'h3333_4444);

        // Reset while waiting for read data: the late rvalid must leave no trace.
        while (!in_ready) tick();
        exp_mem_ok = 1'b1; exp_addr = 32'h0000_0200;
        in_valid = 1'b1; in_sel = 2'b00; in_rd = 5'd12; in_alu = 32'h0000_0200; in_funct3 = 3'b010;
        tick();
        in_valid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        checkResetOutputs("rst_wait");
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        tick();
        mem_rvalid = 1'b0;
        checkResetOutputs("after_rst");
        exp_mem_ok = 1'b0;

        for (int i = 0; i < 150; i++) begin
            logic [2:0] f3;
            f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
            applyStimulus($sformatf("rnd%0d", i), 2'($urandom), 5'($urandom), $urandom, $urandom,
                          $urandom, f3, $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
        end

        repeat (10) tick();
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
